// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the default operand width.
package alu_pkg;

    localparam int unsigned DEFAULT_DATA_W = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational two's-complement ALU; o_err flags signed overflow on ADD/SUB only.
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_out,
    output logic              o_err
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_out = '0;
        o_err = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_out = w_sum;
                // Overflow when both operands share a sign the result does not.
                o_err = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                o_out = w_diff;
                o_err = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_NAND: o_out = ~(i_a & i_b);
            default: o_out = i_a ^ i_b;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters, with a
// single tagged result register and a saturating overflow counter.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [1:0]          req0_op,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [1:0]          req1_op,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_data,
    output logic                res_err,
    output logic                res_id,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic                w_slot_free;
    logic                w_grant;
    logic                w_accept;
    logic [1:0]          w_op;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_alu_out;
    logic                w_alu_err;

    logic                r_last_grant;
    logic                r_res_valid;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_res_err;
    logic                r_res_id;
    logic [ERRCNT_W-1:0] r_err_cnt;

    // Slot counts as free in the same cycle the consumer drains it.
    assign w_slot_free = ~r_res_valid | res_ready;

    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign req0_ready = ~w_grant & req0_valid & w_slot_free;
    assign req1_ready =  w_grant & req1_valid & w_slot_free;
    assign w_accept   = req0_ready | req1_ready;

    always_comb begin
        w_op = req0_op;
        w_a  = req0_a;
        w_b  = req0_b;
        if (w_grant) begin
            w_op = req1_op;
            w_a  = req1_a;
            w_b  = req1_b;
        end
    end

    alu_share_arbiter_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .i_op  (w_op),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_out (w_alu_out),
        .o_err (w_alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_err    <= 1'b0;
            r_res_id     <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_res_valid  <= 1'b1;
            r_res_data   <= w_alu_out;
            r_res_err    <= w_alu_err;
            r_res_id     <= w_grant;
            if (w_alu_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
            end
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign res_id    = r_res_id;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a negedge monitor models arbitration
// and ALU results; scenario tasks add directed checks.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int DW = 4;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op = '0, req1_op = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          res_valid, res_err, res_id;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic [EW-1:0] err_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          id;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    int   checks = 0;
    int   errors = 0;
    logic m_valid = 1'b0;
    logic m_last = 1'b1;
    int   m_errcnt = 0;

    alu_share_arbiter #(
        .DATA_W  (DW),
        .ERRCNT_W(EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_op   (req0_op),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_op   (req1_op),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_id    (res_id),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [1:0] op, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic id);
        exp_t e;
        int   sa, sbv, r;
        sa  = $signed(a);
        sbv = $signed(b);
        e.id  = id;
        e.err = 1'b0;
        case (op)
            2'b00, 2'b01: begin
                r = (op == 2'b00) ? sa + sbv : sa - sbv;
                e.data = r[DW-1:0];
                e.err  = (r > 7) || (r < -8);
            end
            2'b10:   e.data = ~(a & b);
            default: e.data = a ^ b;
        endcase
        return e;
    endfunction

    always @(negedge rst_n) begin
        m_valid  = 1'b0;
        m_last   = 1'b1;
        m_errcnt = 0;
        sb.delete();
    end

    always @(negedge clk) begin
        logic sf, g, e0, e1;
        exp_t e, got;
        if (rst_n) begin
            checks++;
            if (res_valid !== m_valid) begin
                errors++;
                $display("FAIL mon_res_valid: got %b expected %b", res_valid, m_valid);
            end
            checks++;
            if (err_cnt !== EW'(m_errcnt)) begin
                errors++;
                $display("FAIL mon_err_cnt: got %0d expected %0d", err_cnt, m_errcnt);
            end
            sf = !m_valid || res_ready;
            g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0 = req0_valid && !g && sf;
            e1 = req1_valid && g && sf;
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++;
                $display("FAIL mon_ready: got %b%b expected %b%b", req1_ready, req0_ready, e1, e0);
            end
            if (m_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got result with no expectation queued");
                end else begin
                    got = sb.pop_front();
                    if (res_data !== got.data || res_err !== got.err || res_id !== got.id) begin
                        errors++;
                        $display("FAIL sb_result: got data=%0h err=%b id=%b expected data=%0h err=%b id=%b",
                                 res_data, res_err, res_id, got.data, got.err, got.id);
                    end
                end
            end
            if (e0 || e1) begin
                e = g ? model(req1_op, req1_a, req1_b, 1'b1) : model(req0_op, req0_a, req0_b, 1'b0);
                sb.push_back(e);
                acc_log.push_back(int'(g));
                m_last  = g;
                m_valid = 1'b1;
                if (e.err && m_errcnt < 255) m_errcnt++;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic set0(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    endtask

    task automatic chk_res(input string name, input logic v, input logic [DW-1:0] d,
                           input logic er, input logic id);
        checks++;
        if (res_valid !== v || res_data !== d || res_err !== er || res_id !== id) begin
            errors++;
            $display("FAIL %s: got v=%b data=%0h err=%b id=%b expected v=%b data=%0h err=%b id=%b",
                     name, res_valid, res_data, res_err, res_id, v, d, er, id);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        res_ready = 1'b1;
        set0(OP_ADD, 4'd0, 4'd0);
        repeat (2) tick();
        checks++;
        if (res_valid !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b cnt=%0d expected v=0 cnt=0", res_valid, err_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_ready: got %b expected 1", req0_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_single();
        set0(OP_ADD, 4'd3, 4'd2);
        tick();
        idle();
        chk_res("single_add", 1'b1, 4'd5, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_contention();
        set1(OP_NAND, 4'hF, 4'h3);
        tick();
        idle();
        tick();
        acc_log.delete();
        set0(OP_ADD, 4'd1, 4'd1);
        set1(OP_XOR, 4'd5, 4'd3);
        repeat (4) tick();
        idle();
        checks++;
        if (acc_log.size() != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d expected 4", acc_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc_log[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL contention_order: slot %0d got %0d expected %0d", i, acc_log[i], i % 2);
                    break;
                end
            end
        end
        tick();
    endtask

    task automatic test_overflow();
        set1(OP_ADD, 4'd7, 4'd1);
        tick();
        idle();
        chk_res("ovf_add", 1'b1, 4'b1000, 1'b1, 1'b1);
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovf_cnt1: got %0d expected 1", err_cnt);
        end
        set0(OP_SUB, 4'h8, 4'd1);
        tick();
        idle();
        chk_res("ovf_sub", 1'b1, 4'd7, 1'b1, 1'b0);
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ovf_cnt2: got %0d expected 2", err_cnt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        set0(OP_ADD, 4'd2, 4'd2);
        set1(OP_NAND, 4'hC, 4'hA);
        tick();
        chk_res("bp_first", 1'b1, 4'h7, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready: got %b%b expected 00", req1_ready, req0_ready);
            end
            tick();
            chk_res("bp_stable", 1'b1, 4'h7, 1'b0, 1'b1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_ready: got %b%b expected 01", req1_ready, req0_ready);
        end
        tick();
        idle();
        chk_res("bp_release", 1'b1, 4'd4, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_midop();
        res_ready = 1'b0;
        set0(OP_ADD, 4'd1, 4'd2);
        tick();
        idle();
        chk_res("midop_loaded", 1'b1, 4'd3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_res("midop_async", 1'b0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (err_cnt !== '0) begin
            errors++;
            $display("FAIL midop_cnt: got %0d expected 0", err_cnt);
        end
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        set0(OP_ADD, 4'd1, 4'd1);
        set1(OP_XOR, 4'd6, 4'd3);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_first_grant: got %b%b expected 01", req1_ready, req0_ready);
        end
        tick();
        idle();
        chk_res("midop_after", 1'b1, 4'd2, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_saturation();
        res_ready = 1'b1;
        set0(OP_ADD, 4'd7, 4'd1);
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 254) begin
                checks++;
                if (err_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_reach: got %0d expected 255", err_cnt);
                end
            end
        end
        idle();
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 255", err_cnt);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        test_saturation();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
